// File: rtl/mult_pkg.sv
// Shared definitions for the radix-2 shift-add multiplier.
//   mult_state_e     : FSM state encoding (idle, iterate, final sign fix-up)
//   DefaultDataWidth : default operand width N
//   DefaultCntWidth  : bit-counter width for the default operand width
//   cnt_width()      : bit-counter width for any operand width (at least 1)
package mult_pkg;

  localparam int unsigned DefaultDataWidth = 32;
  localparam int unsigned DefaultCntWidth  = $clog2(DefaultDataWidth);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StFix  = 2'd2
  } mult_state_e;

  // $clog2(1) is 0, which is not a legal vector width.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/mult_abs_neg.sv
// Combinational sign handling for the radix-2 multiplier.
//   Capture side: conditional magnitude of both N-bit operands and the product sign.
//     sign       in  1 = two's-complement operands
//     a, b       in  N-bit operands
//     mag_a/b    out |a|, |b| when sign=1, otherwise a, b unchanged
//     neg        out product must be negated (sign & (a[N-1] ^ b[N-1]))
//   Fix-up side: conditional 2N-bit negate of the unsigned accumulator.
//     neg_en     in  negate enable
//     wide       in  2N-bit unsigned product
//     wide_out   out neg_en ? -wide : wide
module mult_abs_neg #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    sign,
  input  logic [DATA_WIDTH-1:0]   a,
  input  logic [DATA_WIDTH-1:0]   b,
  output logic [DATA_WIDTH-1:0]   mag_a,
  output logic [DATA_WIDTH-1:0]   mag_b,
  output logic                    neg,
  input  logic                    neg_en,
  input  logic [2*DATA_WIDTH-1:0] wide,
  output logic [2*DATA_WIDTH-1:0] wide_out
);

  logic a_neg;
  logic b_neg;

  always_comb begin
    a_neg = sign & a[DATA_WIDTH-1];
    b_neg = sign & b[DATA_WIDTH-1];
    // -2^(N-1) negates to itself, which read as unsigned is the correct magnitude.
    mag_a    = a_neg ? (~a + 1'b1) : a;
    mag_b    = b_neg ? (~b + 1'b1) : b;
    neg      = a_neg ^ b_neg;
    wide_out = neg_en ? (~wide + 1'b1) : wide;
  end

endmodule

// File: rtl/multiplier_radix2.sv
// Sequential radix-2 shift-add multiplier, one multiplier bit per clock.
// Operands are reduced to magnitudes at capture, multiplied unsigned, and the
// sign is applied once at the end.
//   clk          in  clock, rising edge
//   rst_n        in  asynchronous active-low reset
//   in1, in2     in  multiplicand / multiplier, sampled on the accepted start edge
//   sign         in  1 = two's-complement operands, sampled with the operands
//   start        in  request, accepted only when idle
//   prod_hi_reg  out upper N bits of the product, held until the next result
//   prod_lo_reg  out lower N bits of the product, held until the next result
//   done_reg     out one-cycle pulse when a new product is visible
//   busy         out operation in flight
// Optional feature macro: MULT_EARLY_TERM_EN -- leave the iteration as soon as
// the remaining multiplier bits are all zero.
module multiplier_radix2
  import mult_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefaultDataWidth
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in1,
  input  logic [DATA_WIDTH-1:0] in2,
  input  logic                  sign,
  input  logic                  start,
  output logic [DATA_WIDTH-1:0] prod_hi_reg,
  output logic [DATA_WIDTH-1:0] prod_lo_reg,
  output logic                  done_reg,
  output logic                  busy
);

  localparam int unsigned CntW = cnt_width(DATA_WIDTH);
  localparam int unsigned ProdW = 2 * DATA_WIDTH;
  localparam logic [CntW-1:0] LastCnt = CntW'(DATA_WIDTH - 1);

  mult_state_e state_q, state_d;
  logic [ProdW-1:0]      acc_q, acc_d;
  logic [ProdW-1:0]      mcand_q, mcand_d;
  logic [DATA_WIDTH-1:0] mag_b_q, mag_b_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  neg_q, neg_d;
  logic [ProdW-1:0]      prod_q, prod_d;
  logic                  done_q, done_d;

  logic [DATA_WIDTH-1:0] cap_mag_a;
  logic [DATA_WIDTH-1:0] cap_mag_b;
  logic                  cap_neg;
  logic [ProdW-1:0]      fix_prod;

  mult_abs_neg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_abs_neg (
    .sign    (sign),
    .a       (in1),
    .b       (in2),
    .mag_a   (cap_mag_a),
    .mag_b   (cap_mag_b),
    .neg     (cap_neg),
    .neg_en  (neg_q),
    .wide    (acc_q),
    .wide_out(fix_prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      acc_q   <= '0;
      mcand_q <= '0;
      mag_b_q <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      prod_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      mag_b_q <= mag_b_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      prod_q  <= prod_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    mag_b_d = mag_b_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    prod_d  = prod_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          acc_d   = '0;
          mcand_d = {{DATA_WIDTH{1'b0}}, cap_mag_a};
          mag_b_d = cap_mag_b;
          neg_d   = cap_neg;
          cnt_d   = '0;
          state_d = StCalc;
        end
      end
      StCalc: begin
        if (mag_b_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d = mcand_q << 1;
        mag_b_d = mag_b_q >> 1;
        cnt_d   = cnt_q + CntW'(1);
`ifdef MULT_EARLY_TERM_EN
        if ((cnt_q == LastCnt) || (mag_b_d == '0)) begin
          state_d = StFix;
        end
`else
        if (cnt_q == LastCnt) begin
          state_d = StFix;
        end
`endif
      end
      StFix: begin
        prod_d  = fix_prod;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign prod_hi_reg = prod_q[ProdW-1:DATA_WIDTH];
  assign prod_lo_reg = prod_q[DATA_WIDTH-1:0];
  assign done_reg    = done_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_multiplier_radix2.sv
module tb_multiplier_radix2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in1;
  logic [31:0] in2;
  logic        sign;
  logic        start;
  logic [31:0] prod_hi_reg;
  logic [31:0] prod_lo_reg;
  logic        done_reg;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  multiplier_radix2 #(
    .DATA_WIDTH(32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in1        (in1),
    .in2        (in2),
    .sign       (sign),
    .start      (start),
    .prod_hi_reg(prod_hi_reg),
    .prod_lo_reg(prod_lo_reg),
    .done_reg   (done_reg),
    .busy       (busy)
  );

  // Expected latency in edges after the start edge.
  function automatic int exp_lat(input logic [31:0] b, input logic s);
    logic [31:0] m;
    int bl;
    m  = (s && b[31]) ? (~b + 32'd1) : b;
    bl = 0;
    for (int i = 31; i >= 0; i--) begin
      if (m[i] && bl == 0) bl = i + 1;
    end
`ifdef MULT_EARLY_TERM_EN
    return ((bl < 1) ? 1 : bl) + 1;
`else
    return 33;
`endif
  endfunction

  // Launch one operation and wait (bounded) for done; lat = -1 on timeout.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                       output logic [63:0] p, output int lat);
    @(negedge clk);
    in1 = a; in2 = b; sign = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk); #1;
      if (done_reg) begin
        lat = i;
        break;
      end
    end
    p = {prod_hi_reg, prod_lo_reg};
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; in1 = '0; in2 = '0; sign = 1'b0;
    #12;
    n_checks++;
    if ({prod_hi_reg, prod_lo_reg} !== 64'd0) begin
      n_fail++; $display("FAIL reset_prod: got %h want 0", {prod_hi_reg, prod_lo_reg});
    end
    n_checks++;
    if (done_reg !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: got done=%b busy=%b want 0 0", done_reg, busy);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_unsigned();
    logic [31:0] va [3] = '{32'hFFFFFFFF, 32'h12345678, 32'h80000000};
    logic [31:0] vb [3] = '{32'hFFFFFFFF, 32'h00000010, 32'h00000001};
    logic [63:0] ve [3] = '{64'hFFFFFFFE_00000001, 64'h00000001_23456780,
                            64'h00000000_80000000};
    logic [63:0] p;
    int lat;
    for (int i = 0; i < 3; i++) begin
      do_op(va[i], vb[i], 1'b0, p, lat);
      n_checks++;
      if (p !== ve[i]) begin
        n_fail++; $display("FAIL unsigned_prod[%0d]: got %h want %h", i, p, ve[i]);
      end
      n_checks++;
      if (lat !== exp_lat(vb[i], 1'b0)) begin
        n_fail++;
        $display("FAIL unsigned_lat[%0d]: got %0d want %0d", i, lat, exp_lat(vb[i], 1'b0));
      end
    end
    // Product holds after the done pulse.
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({prod_hi_reg, prod_lo_reg} !== 64'h00000000_80000000 || done_reg !== 1'b0) begin
      n_fail++;
      $display("FAIL hold: got %h done=%b want 0000000080000000 done=0",
               {prod_hi_reg, prod_lo_reg}, done_reg);
    end
  endtask

  task automatic test_signed();
    logic [31:0] va [4] = '{32'hFFFFFFFF, 32'h80000000, 32'h80000000, 32'h00000007};
    logic [31:0] vb [4] = '{32'h00000007, 32'h80000000, 32'h00000001, 32'hFFFFFFFD};
    logic [63:0] ve [4] = '{64'hFFFFFFFF_FFFFFFF9, 64'h40000000_00000000,
                            64'hFFFFFFFF_80000000, 64'hFFFFFFFF_FFFFFFEB};
    logic [63:0] p;
    int lat;
    for (int i = 0; i < 4; i++) begin
      do_op(va[i], vb[i], 1'b1, p, lat);
      n_checks++;
      if (p !== ve[i]) begin
        n_fail++; $display("FAIL signed_prod[%0d]: got %h want %h", i, p, ve[i]);
      end
      n_checks++;
      if (lat !== exp_lat(vb[i], 1'b1)) begin
        n_fail++;
        $display("FAIL signed_lat[%0d]: got %0d want %0d", i, lat, exp_lat(vb[i], 1'b1));
      end
    end
  endtask

  task automatic test_zero_mult();
    logic [63:0] p;
    int lat;
    do_op(32'h12345678, 32'h00000000, 1'b0, p, lat);
    n_checks++;
    if (p !== 64'd0) begin
      n_fail++; $display("FAIL zero_prod: got %h want 0", p);
    end
    n_checks++;
`ifdef MULT_EARLY_TERM_EN
    if (lat !== 2) begin
      n_fail++; $display("FAIL zero_lat: got %0d want 2", lat);
    end
`else
    if (lat !== 33) begin
      n_fail++; $display("FAIL zero_lat: got %0d want 33", lat);
    end
`endif
    do_op(32'h00000001, 32'h00000010, 1'b0, p, lat);
    n_checks++;
    if (p !== 64'h10) begin
      n_fail++; $display("FAIL x10_prod: got %h want 10", p);
    end
    n_checks++;
`ifdef MULT_EARLY_TERM_EN
    if (lat !== 6) begin
      n_fail++; $display("FAIL x10_lat: got %0d want 6", lat);
    end
`else
    if (lat !== 33) begin
      n_fail++; $display("FAIL x10_lat: got %0d want 33", lat);
    end
`endif
  endtask

  task automatic test_start_while_busy();
    int ndone;
    logic [63:0] p;
    @(negedge clk);
    in1 = 32'h00001234; in2 = 32'h00000100; sign = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    in1 = 32'hFFFFFFFF; in2 = 32'hFFFFFFFF; sign = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0;
    p = '0;
    for (int i = 0; i < 90; i++) begin
      @(posedge clk); #1;
      if (done_reg) begin
        ndone++;
        if (ndone == 1) p = {prod_hi_reg, prod_lo_reg};
      end
    end
    n_checks++;
    if (ndone !== 1) begin
      n_fail++; $display("FAIL busy_done_count: got %0d want 1", ndone);
    end
    n_checks++;
    if (p !== 64'h00000000_00123400) begin
      n_fail++; $display("FAIL busy_prod: got %h want 0000000000123400", p);
    end
  endtask

  task automatic test_back_to_back();
    bit seen;
    @(negedge clk);
    in1 = 32'h0000000B; in2 = 32'h0000000D; sign = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (done_reg) begin
        seen = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!seen || {prod_hi_reg, prod_lo_reg} !== 64'd143) begin
      n_fail++;
      $display("FAIL b2b_first: got seen=%0b prod=%h want 1 8f", seen, {prod_hi_reg, prod_lo_reg});
    end
    // Start during the done cycle.
    in1 = 32'hFFFFFFFE; in2 = 32'h00000003; sign = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || done_reg !== 1'b0) begin
      n_fail++; $display("FAIL b2b_accept: got busy=%b done=%b want 1 0", busy, done_reg);
    end
    n_checks++;
    if ({prod_hi_reg, prod_lo_reg} !== 64'd143) begin
      n_fail++; $display("FAIL b2b_held: got %h want 8f", {prod_hi_reg, prod_lo_reg});
    end
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (done_reg) begin
        seen = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!seen || {prod_hi_reg, prod_lo_reg} !== 64'hFFFFFFFF_FFFFFFFA) begin
      n_fail++;
      $display("FAIL b2b_second: got seen=%0b prod=%h want 1 fffffffffffffffa",
               seen, {prod_hi_reg, prod_lo_reg});
    end
  endtask

  task automatic test_reset_mid_calc();
    logic [63:0] p;
    int lat;
    @(negedge clk);
    in1 = 32'h00001234; in2 = 32'h00005678; sign = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || done_reg !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_flags: got busy=%b done=%b want 0 0", busy, done_reg);
    end
    n_checks++;
    if ({prod_hi_reg, prod_lo_reg} !== 64'd0) begin
      n_fail++; $display("FAIL rst_mid_prod: got %h want 0", {prod_hi_reg, prod_lo_reg});
    end
    @(negedge clk); rst_n = 1'b1;
    do_op(32'h00000003, 32'h00000005, 1'b0, p, lat);
    n_checks++;
    if (p !== 64'h0F) begin
      n_fail++; $display("FAIL rst_after_prod: got %h want f", p);
    end
    n_checks++;
    if (lat !== exp_lat(32'h5, 1'b0)) begin
      n_fail++; $display("FAIL rst_after_lat: got %0d want %0d", lat, exp_lat(32'h5, 1'b0));
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_zero_mult();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_calc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multiplier_radix2.md
# multiplier_radix2

Sequential radix-2 shift-add multiplier: the multiply counterpart of the team's radix-2 divider. Accepts two DATA_WIDTH-bit operands, signed or unsigned, on a `start` pulse, iterates one multiplier bit per clock, and returns the 2·DATA_WIDTH-bit product with a `done_reg` pulse. It shares the divider's start/done handshake, so the same bench style and file-driven vectors apply.

## Interface
- DATA_WIDTH, 32: operand width N; the product is 2N bits wide.
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in1  input  N  multiplicand; sampled only on the start edge.
- in2  input  N  multiplier; sampled only on the start edge.
- sign  input  1  1 = two's-complement operands, 0 = unsigned; sampled on the start edge.
- start  input  1  request; accepted only in IDLE.
- prod_hi_reg  output  N  upper half of the product.
- prod_lo_reg  output  N  lower half of the product.
- done_reg  output  1  one-cycle pulse; the product registers are valid from this cycle onward.
- busy  output  1  high in CALC and FIX.

## Operation
- States:
  - IDLE: start=1 → capture operands → CALC.
  - CALC: one bit per edge; last bit → FIX.
  - FIX: → IDLE.
- Capture on the start edge:
  - mag_a = |in1| and mag_b = |in2| when sign=1; otherwise the raw values.
  - neg = sign & (in1[N-1] ^ in2[N-1]).
  - acc = 0; mcand (2N bits) = zero-extended mag_a; bit counter = 0.
- Each CALC edge:
  - If mag_b[0], then acc += mcand (2N-bit add, no overflow possible).
  - mcand <<= 1; mag_b >>= 1; counter++.
  - Go to FIX when counter reaches N-1 before the increment.
- FIX edge:
  - {prod_hi_reg, prod_lo_reg} = neg ? -acc : acc.
  - done_reg = 1.
- Signed case: -2^(N-1) has magnitude 2^(N-1), which fits in N unsigned bits. (-2^31)·(-2^31) = 2^62 is exact.
- start while busy: ignored. The operands in flight are unaffected.
- start on the same edge as done_reg: accepted, because the FSM is already in IDLE.
- Product registers hold their last value until the next FIX edge; they are never cleared by start.
- Reset mid-operation: all state is abandoned immediately and the FSM returns to IDLE. The next start behaves normally.

## Timing
- Reset values: prod_hi_reg=0, prod_lo_reg=0, done_reg=0, busy=0, FSM=IDLE.
- The start edge is edge 0.
- Edges 1..N are CALC and edge N+1 is FIX. done_reg is high during the cycle after edge N+1 and cleared at edge N+2.
- Fixed latency without early termination: N+1 edges (33 for N=32).
- busy rises after edge 0 and falls after edge N+1 (same edge at which done_reg rises).
- Minimum start-to-start spacing: N+2 edges.

## Configuration
- MULT_EARLY_TERM_EN:
  - Defined: CALC also exits to FIX when the post-shift mag_b is zero. Latency becomes max(1, bitlength(mag_b)) + 1 edges, so a zero multiplier gives done_reg after edge 2.
  - Undefined: fixed N+1 latency. The bench must key on done_reg, never on a cycle count.

## Structure
- Shared package mult_pkg:
  - FSM state enum {IDLE, CALC, FIX}.
  - DATA_WIDTH default constant.
  - Counter width $clog2(DATA_WIDTH).
- Sub-module mult_abs_neg: combinational conditional magnitude (N bits) and conditional 2N-bit negate. It is used at capture and at FIX.
- Top level holds only the FSM and the datapath registers.

## Test plan
- Reset asserted mid-CALC, then start with u 00000003 × 00000005 → FSM goes to IDLE and outputs clear to 0; the following operation completes with product 0x0000000F.
- u FFFFFFFF × FFFFFFFF → hi=FFFFFFFE, lo=00000001; done after exactly 33 edges (macro off).
- s FFFFFFFF (−1) × 00000007 → hi=FFFFFFFF, lo=FFFFFFF9. s 80000000 × 80000000 → hi=40000000, lo=00000000.
- s 80000000 × 00000001 → hi=FFFFFFFF, lo=80000000. Under the same operands, u → hi=00000000, lo=80000000.
- start pulsed again mid-CALC with different operands → ignored; the original product is returned and done_reg pulses exactly once.
- MULT_EARLY_TERM_EN defined: u 12345678 × 00000000 → product 0 with done after edge 2. u 00000001 × 00000010 → product 0x10 with done after edge 6. Back-to-back start on the done cycle is accepted.
